operand_fetch: RTL and testbench
================================

# operand_fetch

Read-side companion to `register_bank`: it turns source-register requests from the decode stage into 16-bit operands taken from the bank's flattened 128-bit `Q` bus, and presents them to the ALU through a one-entry output buffer. A destination scoreboard tracks registers with an outstanding write-back and stalls any request that would read stale data. Write-back observation uses the same one-hot `en` / `alu_data` pair that drives the bank.

## Interface
Parameters:
- `NREG`, 8: number of registers; must match the bank.
- `DW`, 16: register width; `Q` is `NREG*DW` bits.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: decode presents a request.
- `req_ready`  out  1: request accepted this cycle when `req_valid && req_ready`.
- `rs_a`, `rs_b`  in  3 each: source register indices.
- `rd_valid`  in  1: the request will write back a result.
- `rd`  in  3: destination index.
- `Q`  in  128: bank contents; register i is `Q[16*i+15:16*i]`.
- `en`  in  8: one-hot write-back enable, as driven to the bank.
- `alu_data`  in  16: write-back data, as driven to the bank.
- `op_valid`  out  1: operands are held in the output buffer.
- `op_ready`  in  1: the ALU consumes operands when `op_valid && op_ready`.
- `op_a`, `op_b`  out  16 each: fetched operands.
- `op_rd`  out  3: destination index passed through to the ALU.
- `op_rd_valid`  out  1: pass-through of `rd_valid`.
- `pending`  out  8: scoreboard, exported for debug.

## Operation
- The bank updates `Q` on the edge that samples `en`. `Q` therefore shows new data in the cycle after `en` is asserted.
- Output buffer has two states, EMPTY and FULL.
  - EMPTY to FULL on an accepted request.
  - FULL to EMPTY on consume with no new accept.
  - FULL stays FULL on simultaneous consume and accept; the buffer reloads.
- Hazard condition: `hz = pending[rs_a] | pending[rs_b]`, after the bypass rules in Configuration are applied.
- Ready rule: `req_ready = !hz && (state==EMPTY || op_ready)`.
- Scoreboard update each cycle:
  - `pending <= (pending & ~en) | set`.
  - `set` is the one-hot of `rd` when a request with `rd_valid` is accepted.
  - If set and clear hit the same bit in the same cycle, set wins; the register stays pending for the new writer.
- `en` with more than one bit set is illegal input. If it occurs, every asserted bit is cleared, and the bypass takes `alu_data` for each matching source.
- Reset values:
  - `op_valid=0`; state EMPTY.
  - `pending=0`.
  - `op_a`, `op_b`, `op_rd` = 0; `op_rd_valid=0`.
  - `req_ready` is 1 after reset, since the buffer is empty and no register is pending.
- Reset asserted mid-operation drops the buffered operands and clears the scoreboard in the same edge.

## Timing
- Latency is 1 cycle: operands captured at the accepting edge appear on `op_a`/`op_b` with `op_valid=1` in the next cycle.
- Throughput is one request per cycle while `op_ready=1` and no hazard is present.
- Outputs stay stable while `op_valid && !op_ready`.
- `req_ready` is combinational from `req_*`, `en`, `op_ready` and state. `op_*` are registered.
- Without bypass, a read of register r stalls through the write-back cycle and the following cycle. It is accepted 2 cycles after the `en[r]` cycle at the earliest.

## Configuration
Macro: `OPFETCH_BYPASS_EN`.

Defined:
- An operand whose source index matches an asserted `en` bit takes `alu_data` instead of `Q`.
- That source's pending bit is ignored for `hz`, so the request is accepted in the same cycle as the write-back.
- A register cleared on the previous edge reads `Q`, which is already updated.

Undefined:
- No forwarding path.
- A source is also hazarded for one cycle after its `en` bit, covering the bank update; this needs an 8-bit `recent` register, set from `en` and cleared the next cycle.
- Operands always come from `Q`.

## Structure
- Shared package `cpu_pkg`:
  - `NREG`, `DW`.
  - Register index type (3 bits).
  - Buffer state enum (EMPTY, FULL).
  - Function for the one-hot to index mapping.
- One sub-module, `reg_read_mux`: combinational 16-bit slice selector from `Q` by index, with optional bypass compare. It is instantiated twice, once for port A and once for port B.

## Test plan
- Reset, then bank preloaded so R1=0x000F and R2=0x00A0. Request `rs_a=1`, `rs_b=2` → next cycle `op_valid=1`, `op_a=0x000F`, `op_b=0x00A0`.
- Accept a request with `rd_valid=1`, `rd=3` → `pending=0x08`. A following request reading R3 sees `req_ready=0`.
- Same setup, then `en=0x08`, `alu_data=0x1234`:
  - Bypass build: accepted that cycle with `op_a=0x1234`.
  - Non-bypass build: accepted 2 cycles later with `op_a` read from `Q`.
- Hold `op_ready=0` with the buffer FULL → `op_*` stable and `req_ready=0`. Release `op_ready` for one cycle while `req_valid=1` → simultaneous consume and accept, new operands next cycle.
- Same-cycle `en=0x10` clear and accepted request with `rd=4` → `pending[4]` stays 1.
- Assert `rst` while FULL with `pending=0xFF` → next cycle `op_valid=0`, `pending=0`, all `op_*` outputs 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the register-read path: sizes, register index
// type, output-buffer state encoding and one-hot/index helpers.
package cpu_pkg;

  localparam int NREG  = 8;
  localparam int DW    = 16;
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  // Lowest-to-highest OR of set bit positions; exact for a legal one-hot input.
  function automatic reg_idx_t onehot_to_idx(input logic [NREG-1:0] oh);
    reg_idx_t idx;
    idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (oh[i]) idx = idx | reg_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic logic [NREG-1:0] idx_to_onehot(input reg_idx_t idx);
    logic [NREG-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/reg_read_mux.sv
// Selects one DW-bit register from the flattened bank bus. When BYPASS is
// set, a source whose index matches an asserted write-back enable takes the
// write-back data instead, since the bank has not captured it yet.
module reg_read_mux
  import cpu_pkg::*;
#(
  parameter int NREG   = cpu_pkg::NREG,
  parameter int DW     = cpu_pkg::DW,
  parameter bit BYPASS = 1'b0
) (
  input  logic [NREG*DW-1:0] q_i,
  input  reg_idx_t           idx_i,
  input  logic [NREG-1:0]    en_i,
  input  logic [DW-1:0]      wb_data_i,
  output logic [DW-1:0]      data_o
);

  // Forward the in-flight write-back when enabled, otherwise read the bank.
  always_comb begin
    data_o = q_i[idx_i*DW +: DW];
    if (BYPASS && en_i[idx_i]) data_o = wb_data_i;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads two source registers from the bank bus into a
// one-entry output buffer, stalling requests that would read a register
// with an outstanding write-back.
// Build option: define OPFETCH_BYPASS_EN to forward write-back data to
// matching sources in the write-back cycle; without it a source also stalls
// for the cycle after its write-back while the bank bus catches up.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int NREG = cpu_pkg::NREG,
  parameter int DW   = cpu_pkg::DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  reg_idx_t           rs_a,
  input  reg_idx_t           rs_b,
  input  logic               rd_valid,
  input  reg_idx_t           rd,
  input  logic [NREG*DW-1:0] Q,
  input  logic [NREG-1:0]    en,
  input  logic [DW-1:0]      alu_data,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [DW-1:0]      op_a,
  output logic [DW-1:0]      op_b,
  output reg_idx_t           op_rd,
  output logic               op_rd_valid,
  output logic [NREG-1:0]    pending
);

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  buf_state_t       state_q, state_d;
  logic [NREG-1:0]  pending_q, pending_d;
  logic [NREG-1:0]  set_mask;
  logic [NREG-1:0]  blocked;
  logic [DW-1:0]    op_a_q, op_b_q;
  logic [DW-1:0]    rd_a, rd_b;
  reg_idx_t         op_rd_q;
  logic             op_rd_valid_q;
  logic             hz;
  logic             accept;
  logic             consume;

`ifdef OPFETCH_BYPASS_EN
  // A write-back in flight is forwarded, so its pending bit no longer blocks.
  assign blocked = pending_q & ~en;
`else
  logic [NREG-1:0] recent_q;

  // Remember last cycle's write-backs: the bank bus shows them only now.
  always_ff @(posedge clk) begin
    if (rst) recent_q <= '0;
    else     recent_q <= en;
  end

  assign blocked = pending_q | recent_q;
`endif

  assign hz        = blocked[rs_a] | blocked[rs_b];
  assign req_ready = !hz && (state_q == EMPTY || op_ready);
  assign accept    = req_valid && req_ready;
  assign consume   = (state_q == FULL) && op_ready;

  reg_read_mux #(.NREG(NREG), .DW(DW), .BYPASS(BYPASS)) u_mux_a (
    .q_i       (Q),
    .idx_i     (rs_a),
    .en_i      (en),
    .wb_data_i (alu_data),
    .data_o    (rd_a)
  );

  reg_read_mux #(.NREG(NREG), .DW(DW), .BYPASS(BYPASS)) u_mux_b (
    .q_i       (Q),
    .idx_i     (rs_b),
    .en_i      (en),
    .wb_data_i (alu_data),
    .data_o    (rd_b)
  );

  // Output buffer next state: fill on accept, drain on consume without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (consume && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Scoreboard next state: clear on write-back, then set for a new writer so
  // a same-cycle set and clear leaves the bit pending.
  always_comb begin
    set_mask  = '0;
    if (accept && rd_valid) set_mask = idx_to_onehot(rd);
    pending_d = (pending_q & ~en) | set_mask;
  end

  // Control and buffered operands; reset drops any held operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      pending_q     <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_rd_q       <= '0;
      op_rd_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (accept) begin
        op_a_q        <= rd_a;
        op_b_q        <= rd_b;
        op_rd_q       <= rd;
        op_rd_valid_q <= rd_valid;
      end
    end
  end

  assign op_valid    = (state_q == FULL);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_rd       = op_rd_q;
  assign op_rd_valid = op_rd_valid_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural bank drives Q, a scoreboard queue
// holds the operands expected from each accepted request, and a small
// scoreboard/ready model tracks pending registers.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  rs_a, rs_b, rd;
  logic        rd_valid;
  logic [127:0] Q;
  logic [7:0]  en;
  logic [15:0] alu_data;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a, op_b;
  logic [2:0]  op_rd;
  logic        op_rd_valid;
  logic [7:0]  pending;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rd;
    logic        rdv;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] bank[8];
  logic [7:0]  pend_m;
  logic [7:0]  recent_m;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    Q = '0;
    for (int i = 0; i < 8; i++) Q[i*16 +: 16] = bank[i];
  end

  operand_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .rs_a        (rs_a),
    .rs_b        (rs_b),
    .rd_valid    (rd_valid),
    .rd          (rd),
    .Q           (Q),
    .en          (en),
    .alu_data    (alu_data),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_rd       (op_rd),
    .op_rd_valid (op_rd_valid),
    .pending     (pending)
  );

  // One clock cycle: check against the model just before the edge, update
  // the model and the bank just after it, return at the falling edge.
  task automatic step();
    logic [7:0] blk;
    logic [7:0] set;
    logic       hz, exp_ready;
    exp_t       e;
    #3;
    if (!rst) begin
`ifdef OPFETCH_BYPASS_EN
      blk = pend_m & ~en;
`else
      blk = pend_m | recent_m;
`endif
      hz        = blk[rs_a] | blk[rs_b];
      exp_ready = !hz && (sb.size() == 0 || op_ready);
      n_cmp++;
      if (req_ready !== exp_ready) begin
        n_err++;
        $display("FAIL req_ready @%0t: got %b want %b", $time, req_ready, exp_ready);
      end
      n_cmp++;
      if (pending !== pend_m) begin
        n_err++;
        $display("FAIL pending @%0t: got %h want %h", $time, pending, pend_m);
      end
      n_cmp++;
      if (op_valid !== (sb.size() != 0)) begin
        n_err++;
        $display("FAIL op_valid @%0t: got %b want %b", $time, op_valid, sb.size() != 0);
      end
      if (sb.size() != 0) begin
        e = sb[0];
        n_cmp++;
        if ({op_a, op_b, op_rd, op_rd_valid} !== e) begin
          n_err++;
          $display("FAIL operands @%0t: got a=%h b=%h rd=%0d v=%b want a=%h b=%h rd=%0d v=%b",
                   $time, op_a, op_b, op_rd, op_rd_valid, e.a, e.b, e.rd, e.rdv);
        end
        if (op_ready) void'(sb.pop_front());
      end
      set = '0;
      if (req_valid && exp_ready) begin
`ifdef OPFETCH_BYPASS_EN
        e.a = en[rs_a] ? alu_data : bank[rs_a];
        e.b = en[rs_b] ? alu_data : bank[rs_b];
`else
        e.a = bank[rs_a];
        e.b = bank[rs_b];
`endif
        e.rd  = rd;
        e.rdv = rd_valid;
        sb.push_back(e);
        if (rd_valid) set = 8'b1 << rd;
      end
      pend_m   = (pend_m & ~en) | set;
      recent_m = en;
    end else begin
      sb.delete();
      pend_m   = '0;
      recent_m = '0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) if (en[i]) bank[i] = alu_data;
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0; rd_valid = 1'b0; en = '0;
  endtask

  task automatic write_reg(input logic [2:0] r, input logic [15:0] v);
    en = 8'b1 << r; alu_data = v;
    step();
    en = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); op_ready = 1'b1; rs_a = '0; rs_b = '0; rd = '0; alu_data = '0;
    step(); step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({op_valid, pending, op_a, op_b, op_rd, op_rd_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b p=%h a=%h b=%h rd=%0d rv=%b want all 0",
               op_valid, pending, op_a, op_b, op_rd, op_rd_valid);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic_read();
    for (int i = 0; i < 8; i++) write_reg(3'(i), 16'h1111 * 16'(i));
    write_reg(3'd1, 16'h000F);
    write_reg(3'd2, 16'h00A0);
    step();
    req_valid = 1'b1; rs_a = 3'd1; rs_b = 3'd2; rd_valid = 1'b0;
    step();
    idle();
    n_cmp++;
    if ({op_valid, op_a, op_b} !== {1'b1, 16'h000F, 16'h00A0}) begin
      n_err++;
      $display("FAIL basic_read: got v=%b a=%h b=%h want v=1 a=000f b=00a0", op_valid, op_a, op_b);
    end
    step();
  endtask

  task automatic test_hazard();
    op_ready = 1'b1;
    req_valid = 1'b1; rs_a = 3'd0; rs_b = 3'd0; rd_valid = 1'b1; rd = 3'd3;
    step();
    n_cmp++;
    if (pending !== 8'h08) begin
      n_err++;
      $display("FAIL hazard_set: got pending=%h want 08", pending);
    end
    rs_a = 3'd3; rs_b = 3'd0; rd_valid = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL hazard_stall: got req_ready=%b want 0", req_ready);
    end
    step();
    en = 8'h08; alu_data = 16'h1234;
`ifdef OPFETCH_BYPASS_EN
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_accept: got req_ready=%b want 1", req_ready);
    end
    step();
    en = '0;
`else
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL wb_cycle_stall: got req_ready=%b want 0", req_ready);
    end
    step();
    en = '0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL recent_stall: got req_ready=%b want 0", req_ready);
    end
    step();
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL late_accept: got req_ready=%b want 1", req_ready);
    end
    step();
`endif
    idle();
    n_cmp++;
    if ({op_valid, op_a} !== {1'b1, 16'h1234}) begin
      n_err++;
      $display("FAIL hazard_data: got v=%b a=%h want v=1 a=1234", op_valid, op_a);
    end
    step(); step();
  endtask

  task automatic test_backpressure();
    op_ready = 1'b0;
    req_valid = 1'b1; rs_a = 3'd1; rs_b = 3'd2; rd_valid = 1'b0;
    step();
    rs_a = 3'd2; rs_b = 3'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if ({req_ready, op_valid, op_a, op_b} !== {1'b0, 1'b1, 16'h000F, 16'h00A0}) begin
        n_err++;
        $display("FAIL hold_%0d: got rdy=%b v=%b a=%h b=%h want rdy=0 v=1 a=000f b=00a0",
                 k, req_ready, op_valid, op_a, op_b);
      end
      step();
    end
    op_ready = 1'b1;
    step();
    op_ready = 1'b0; idle();
    n_cmp++;
    if ({op_valid, op_a, op_b} !== {1'b1, 16'h00A0, 16'h000F}) begin
      n_err++;
      $display("FAIL reload: got v=%b a=%h b=%h want v=1 a=00a0 b=000f", op_valid, op_a, op_b);
    end
    step();
    op_ready = 1'b1;
    step(); step();
  endtask

  task automatic test_set_wins();
    op_ready = 1'b1;
    req_valid = 1'b1; rs_a = 3'd0; rs_b = 3'd0; rd_valid = 1'b1; rd = 3'd4;
    step();
    en = 8'h10; alu_data = 16'h4444;
    step();
    idle();
    n_cmp++;
    if (pending[4] !== 1'b1) begin
      n_err++;
      $display("FAIL set_wins: got pending=%h want bit4 set", pending);
    end
    en = 8'h10; alu_data = 16'h4545;
    step();
    idle();
    step(); step();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rs_a      = 3'($urandom_range(0, 7));
      rs_b      = 3'($urandom_range(0, 7));
      rd        = 3'($urandom_range(0, 7));
      rd_valid  = $urandom_range(0, 1) != 0;
      op_ready  = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 2) == 0) ? (8'b1 << $urandom_range(0, 7)) : 8'h00;
      alu_data  = 16'($urandom);
      step();
    end
    idle();
  endtask

  task automatic clear_pending();
    idle(); op_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (pend_m[i]) begin
        en = 8'b1 << i; alu_data = 16'($urandom);
        step();
      end
    end
    en = '0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    op_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; rs_a = 3'(i); rs_b = 3'(i); rd = 3'(i); rd_valid = 1'b1;
      step();
    end
    idle(); op_ready = 1'b0;
    n_cmp++;
    if ({op_valid, pending} !== {1'b1, 8'hFF}) begin
      n_err++;
      $display("FAIL prefill: got v=%b pending=%h want v=1 pending=ff", op_valid, pending);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({op_valid, pending, op_a, op_b, op_rd, op_rd_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b p=%h a=%h b=%h rd=%0d rv=%b want all 0",
               op_valid, pending, op_a, op_b, op_rd, op_rd_valid);
    end
    op_ready = 1'b1;
    step(); step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) bank[i] = '0;
    pend_m = '0; recent_m = '0;
    test_reset();
    test_basic_read();
    test_hazard();
    test_backpressure();
    test_set_wins();
    test_back_to_back();
    clear_pending();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
